// File: rtl/addr_lookup_arbiter.sv
// Round-robin arbiter sharing one MAC table lookup port among NUM_PORTS translators.
// Tracks requester IDs through the fixed-latency table pipeline and routes results back.
module addr_lookup_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int LOOKUP_LAT = 2,
  parameter int PORT_W     = $clog2(NUM_PORTS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_PORTS-1:0]    req_valid_i,
  input  logic [48*NUM_PORTS-1:0] req_addr_i,
  output logic [NUM_PORTS-1:0]    req_ready_o,
  input  logic                    tbl_busy_i,
  output logic                    tbl_lookup_en_o,
  output logic [47:0]             tbl_lookup_addr_o,
  input  logic [PORT_W-1:0]       tbl_port_i,
  input  logic                    tbl_port_valid_i,
  output logic [NUM_PORTS-1:0]    resp_valid_o,
  output logic                    resp_hit_o,
  output logic [PORT_W-1:0]       resp_port_o
);

  logic [PORT_W-1:0]                 rr_ptr;
  logic                              grant_any;
  logic [PORT_W-1:0]                 grant_id;
  logic [PORT_W-1:0]                 issue_id;
  logic [LOOKUP_LAT-1:0]             pipe_valid;
  logic [LOOKUP_LAT-1:0][PORT_W-1:0] pipe_id;

  // Search upward from rr_ptr with wrap; grants are suppressed in reset so ready reads 0.
  always_comb begin
    logic [PORT_W-1:0] cand;
    req_ready_o = '0;
    grant_any   = 1'b0;
    grant_id    = '0;
    cand        = '0;
    if (rst_n && !tbl_busy_i) begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        cand = PORT_W'((32'(rr_ptr) + k) % NUM_PORTS);
        if (!grant_any && req_valid_i[cand]) begin
          grant_any = 1'b1;
          grant_id  = cand;
        end
      end
      req_ready_o[grant_id] = grant_any;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr            <= '0;
      tbl_lookup_en_o   <= 1'b0;
      tbl_lookup_addr_o <= '0;
      issue_id          <= '0;
    end else begin
      tbl_lookup_en_o <= grant_any;
      if (grant_any) begin
        tbl_lookup_addr_o <= req_addr_i[48*grant_id +: 48];
        issue_id          <= grant_id;
        rr_ptr            <= (int'(grant_id) == NUM_PORTS - 1) ? '0 : grant_id + 1'b1;
      end
    end
  end

  // ID tracker: one stage per table cycle, never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= '0;
      pipe_id    <= '0;
    end else begin
      pipe_valid[0] <= tbl_lookup_en_o;
      pipe_id[0]    <= issue_id;
      for (int unsigned s = 1; s < LOOKUP_LAT; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        pipe_id[s]    <= pipe_id[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_o <= '0;
      resp_hit_o   <= 1'b0;
      resp_port_o  <= '0;
    end else begin
      resp_valid_o <= '0;
      if (pipe_valid[LOOKUP_LAT-1]) begin
        resp_valid_o[pipe_id[LOOKUP_LAT-1]] <= 1'b1;
        resp_hit_o                          <= tbl_port_valid_i;
        resp_port_o                         <= tbl_port_valid_i ? tbl_port_i : '0;
      end
    end
  end

endmodule

// File: tb/tb_addr_lookup_arbiter.sv
// Self-checking bench for addr_lookup_arbiter: directed scenarios plus a randomized run
// compared against a cycle-indexed behavioural model of grant, issue and response timing.
module tb_addr_lookup_arbiter;
  localparam int NP  = 4;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NP-1:0]   req_valid = '0;
  logic [48*NP-1:0] req_addr = '0;
  logic [NP-1:0]   req_ready;
  logic            tbl_busy = 1'b0;
  logic            tbl_en;
  logic [47:0]     tbl_addr;
  logic [1:0]      tbl_port = '0;
  logic            tbl_pv = 1'b0;
  logic [NP-1:0]   resp_valid;
  logic            resp_hit;
  logic [1:0]      resp_port;

  int unsigned checks = 0;
  int unsigned errors = 0;

  addr_lookup_arbiter #(.NUM_PORTS(NP), .LOOKUP_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(req_ready),
    .tbl_busy_i(tbl_busy), .tbl_lookup_en_o(tbl_en), .tbl_lookup_addr_o(tbl_addr),
    .tbl_port_i(tbl_port), .tbl_port_valid_i(tbl_pv),
    .resp_valid_o(resp_valid), .resp_hit_o(resp_hit), .resp_port_o(resp_port)
  );

  always #5 clk = ~clk;

  // Model: fairness pointer, expected registered outputs, and table-sample schedule by cycle.
  int unsigned m_rr;
  logic        m_en;
  logic [47:0] m_addr;
  logic [3:0]  m_rv;
  logic        m_hit;
  logic [1:0]  m_port;
  logic        samp_v [64];
  int unsigned samp_id [64];
  int unsigned cyc = 0;

  task automatic model_reset();
    m_rr = 0; m_en = 1'b0; m_addr = '0; m_rv = '0; m_hit = 1'b0; m_port = '0;
    for (int i = 0; i < 64; i++) begin samp_v[i] = 1'b0; samp_id[i] = 0; end
  endtask

  function automatic logic [3:0] model_grant();
    logic [3:0] g;
    g = '0;
    if (rst_n && !tbl_busy)
      for (int unsigned k = 0; k < NP; k++) begin
        int unsigned p;
        p = (m_rr + k) % NP;
        if (g == 4'd0 && req_valid[p]) g[p] = 1'b1;
      end
    return g;
  endfunction

  // Update the model from the current inputs, then move to 1ns after the next rising edge.
  task automatic advance();
    logic [3:0]  g;
    int unsigned slot;
    g = model_grant();
    slot = cyc % 64;
    if (!rst_n) model_reset();
    else begin
      if (samp_v[slot]) begin
        m_rv = 4'b0001 << samp_id[slot];
        m_hit = tbl_pv;
        m_port = tbl_pv ? tbl_port : 2'd0;
        samp_v[slot] = 1'b0;
      end else m_rv = '0;
      m_en = (g != 4'd0);
      for (int unsigned p = 0; p < NP; p++)
        if (g[p]) begin
          m_addr = req_addr[p*48 +: 48];
          m_rr = (p + 1) % NP;
          samp_v[(cyc + 1 + LAT) % 64] = 1'b1;
          samp_id[(cyc + 1 + LAT) % 64] = p;
        end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    tbl_busy = 1'b0;
    repeat (n) advance();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    req_valid = 4'b1111;
    @(negedge clk);
    checks++; if (req_ready !== 4'd0) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    checks++; if (tbl_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", tbl_en); end
    checks++; if (tbl_addr !== 48'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0", tbl_addr); end
    checks++; if (resp_valid !== 4'd0) begin errors++; $display("FAIL reset_rv: got %b expected 0000", resp_valid); end
    checks++; if (resp_hit !== 1'b0 || resp_port !== 2'd0) begin errors++; $display("FAIL reset_resp: got hit=%b port=%0d expected 0/0", resp_hit, resp_port); end
    advance();
    req_valid = '0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (tbl_en !== 1'b0 || resp_valid !== 4'd0) begin errors++; $display("FAIL post_reset_idle: got en=%b rv=%b expected 0/0000", tbl_en, resp_valid); end
    advance();
  endtask

  task automatic test_single();
    req_addr = '0;
    req_addr[48 +: 48] = 48'hAABBCCDDEEFF;
    tbl_port = 2'd3; tbl_pv = 1'b1;
    req_valid = 4'b0010;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready: got %b expected 0010", req_ready); end
      end else if (k == 1) begin
        checks++; if (tbl_en !== 1'b1 || tbl_addr !== 48'hAABBCCDDEEFF) begin errors++; $display("FAIL single_issue: got en=%b addr=%h expected 1/aabbccddeeff", tbl_en, tbl_addr); end
      end else if (k < 4) begin
        checks++; if (resp_valid !== 4'd0) begin errors++; $display("FAIL single_early_rv: got %b expected 0000 at N+%0d", resp_valid, k); end
      end else begin
        checks++; if (resp_valid !== 4'b0010 || resp_hit !== 1'b1 || resp_port !== 2'd3) begin errors++; $display("FAIL single_resp: got rv=%b hit=%b port=%0d expected 0010/1/3", resp_valid, resp_hit, resp_port); end
      end
      advance();
      req_valid = '0;
    end
    idle(4);
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0; model_reset(); #1; advance(); rst_n = 1'b1;
    for (int p = 0; p < NP; p++) req_addr[p*48 +: 48] = 48'h1000 + 48'(p);
    req_valid = 4'b1111;
    for (int k = 0; k <= 8; k++) begin
      if (k == 8) req_valid = '0;
      @(negedge clk);
      if (k < 8) begin
        checks++; if (req_ready !== (4'b0001 << (k % 4))) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", k, req_ready, 4'b0001 << (k % 4)); end
      end
      if (k > 0) begin
        checks++; if (tbl_en !== 1'b1 || tbl_addr !== 48'h1000 + 48'((k - 1) % 4)) begin errors++; $display("FAIL rr_issue%0d: got en=%b addr=%h expected 1/%h", k, tbl_en, tbl_addr, 48'h1000 + 48'((k - 1) % 4)); end
      end
      advance();
    end
    @(negedge clk);
    checks++; if (tbl_en !== 1'b0) begin errors++; $display("FAIL rr_en_drop: got %b expected 0", tbl_en); end
    idle(6);
  endtask

  task automatic test_miss();
    tbl_port = 2'd2; tbl_pv = 1'b0;
    req_valid = 4'b0001;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL miss_ready: got %b expected 0001", req_ready); end
      end
      if (k == 4) begin
        checks++; if (resp_valid !== 4'b0001 || resp_hit !== 1'b0 || resp_port !== 2'd0) begin errors++; $display("FAIL miss_resp: got rv=%b hit=%b port=%0d expected 0001/0/0", resp_valid, resp_hit, resp_port); end
      end
      advance();
      req_valid = '0;
    end
    idle(4);
  endtask

  task automatic test_busy();
    req_valid = 4'b0100;
    tbl_busy = 1'b1;
    for (int b = 0; b < 4; b++) begin
      if (b == 3) tbl_busy = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== ((b == 3) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL busy_ready%0d: got %b expected %b", b, req_ready, (b == 3) ? 4'b0100 : 4'b0000); end
      checks++; if (tbl_en !== 1'b0) begin errors++; $display("FAIL busy_en%0d: got %b expected 0", b, tbl_en); end
      advance();
    end
    req_valid = '0;
    @(negedge clk);
    checks++; if (tbl_en !== 1'b1) begin errors++; $display("FAIL busy_release_en: got %b expected 1", tbl_en); end
    advance();
    req_valid = 4'b1111;
    tbl_busy = 1'b1;
    for (int b = 0; b < 3; b++) begin
      if (b == 2) tbl_busy = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== ((b == 2) ? 4'b1000 : 4'b0000)) begin errors++; $display("FAIL busy_hold_ptr%0d: got %b expected %b", b, req_ready, (b == 2) ? 4'b1000 : 4'b0000); end
      advance();
    end
    idle(6);
  endtask

  task automatic test_pipelined_ids();
    logic [3:0] exp_rv;
    for (int k = 0; k < 8; k++) begin
      req_valid = (k == 0) ? 4'b0100 : (k == 1) ? 4'b0001 : (k == 2) ? 4'b1000 : 4'b0000;
      tbl_port = 2'($urandom); tbl_pv = 1'($urandom);
      if (k == 3 || k == 4) begin tbl_port = 2'd1; tbl_pv = 1'b1; end
      if (k == 5) begin tbl_port = 2'd0; tbl_pv = 1'b1; end
      @(negedge clk);
      if (k < 3) begin
        checks++; if (req_ready !== req_valid) begin errors++; $display("FAIL pipe_ready%0d: got %b expected %b", k, req_ready, req_valid); end
      end
      exp_rv = (k == 4) ? 4'b0100 : (k == 5) ? 4'b0001 : (k == 6) ? 4'b1000 : 4'b0000;
      if (k >= 3) begin
        checks++; if (resp_valid !== exp_rv) begin errors++; $display("FAIL pipe_rv%0d: got %b expected %b", k, resp_valid, exp_rv); end
      end
      if (k >= 4 && k <= 6) begin
        checks++; if (resp_hit !== 1'b1 || resp_port !== ((k == 6) ? 2'd0 : 2'd1)) begin errors++; $display("FAIL pipe_port%0d: got hit=%b port=%0d expected 1/%0d", k, resp_hit, resp_port, (k == 6) ? 0 : 1); end
      end
      advance();
    end
    idle(2);
  endtask

  task automatic test_reset_midflight();
    req_addr[48 +: 48] = 48'h123456789ABC;
    tbl_port = 2'd3; tbl_pv = 1'b1;
    req_valid = 4'b0010;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rstmf_grant: got %b expected 0010", req_ready); end
    advance();
    req_valid = '0;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (tbl_en !== 1'b0 || tbl_addr !== 48'd0) begin errors++; $display("FAIL rstmf_issue: got en=%b addr=%h expected 0/0", tbl_en, tbl_addr); end
    checks++; if (resp_valid !== 4'd0 || resp_hit !== 1'b0 || resp_port !== 2'd0 || req_ready !== 4'd0) begin errors++; $display("FAIL rstmf_outputs: got rv=%b hit=%b port=%0d ready=%b expected all 0", resp_valid, resp_hit, resp_port, req_ready); end
    advance();
    advance();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (resp_valid !== 4'd0) begin errors++; $display("FAIL rstmf_stale_rv%0d: got %b expected 0000", k, resp_valid); end
      advance();
    end
    req_valid = 4'b1111;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rstmf_ptr: got %b expected 0001", req_ready); end
    advance();
    idle(6);
  endtask

  task automatic test_random();
    logic [3:0] waiting;
    logic [3:0] exp_g;
    waiting = '0;
    for (int c = 0; c < 406; c++) begin
      if (c < 400) req_valid = waiting | 4'($urandom);
      else req_valid = '0;
      for (int p = 0; p < NP; p++)
        if (!waiting[p]) req_addr[p*48 +: 48] = {16'($urandom), $urandom};
      tbl_busy = (c < 400) && ($urandom_range(0, 4) == 0);
      tbl_port = 2'($urandom);
      tbl_pv = 1'($urandom);
      @(negedge clk);
      exp_g = model_grant();
      checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL rand_ready c=%0d: got %b expected %b", c, req_ready, exp_g); end
      checks++; if (tbl_en !== m_en) begin errors++; $display("FAIL rand_en c=%0d: got %b expected %b", c, tbl_en, m_en); end
      checks++; if (tbl_addr !== m_addr) begin errors++; $display("FAIL rand_addr c=%0d: got %h expected %h", c, tbl_addr, m_addr); end
      checks++; if (resp_valid !== m_rv) begin errors++; $display("FAIL rand_rv c=%0d: got %b expected %b", c, resp_valid, m_rv); end
      checks++; if (resp_hit !== m_hit || resp_port !== m_port) begin errors++; $display("FAIL rand_resp c=%0d: got hit=%b port=%0d expected %b/%0d", c, resp_hit, resp_port, m_hit, m_port); end
      waiting = req_valid & ~exp_g;
      advance();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_miss();
    test_busy();
    test_pipelined_ids();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
